// File: rtl/axis_port_arbiter.sv
// ----------------------------------------------------------------------------
// axis_port_arbiter
//
// Wormhole arbiter for one output direction of the XY mesh router. Input
// ports that have routed a packet here compete for a single AXI-Stream output
// link. The winner stays locked to the link until its TLAST beat is accepted.
// Grants rotate round-robin. A wrapping count of completed packets is
// exported for the PMU.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_i         synchronous active-high reset
//   in_tvalid_i   per-input request / flit valid
//   in_tdata_i    per-input flit payload, input k at [k*DATA_WIDTH +: DATA_WIDTH]
//   in_tlast_i    per-input end-of-packet flag
//   in_tready_o   per-input ready; only the granted input can see ready
//   out_tvalid_o  output link valid
//   out_tdata_o   output link payload
//   out_tlast_o   output link end-of-packet flag
//   out_tready_i  output link ready
//   grant_o       one-hot owner of the link, zero while idle
//   busy_o        high while a packet holds the link
//   pkt_cnt_o     completed packet count, wraps to zero
//
// State table:
//   state  | meaning
//   IDLE   | link free; pick the next requester starting at ptr
//   LOCKED | link owned by grant_q until its TLAST beat transfers
// ----------------------------------------------------------------------------
module axis_port_arbiter #(
    parameter int N_INPUTS   = 5,
    parameter int DATA_WIDTH = 40,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [N_INPUTS-1:0]            in_tvalid_i,
    input  logic [N_INPUTS*DATA_WIDTH-1:0] in_tdata_i,
    input  logic [N_INPUTS-1:0]            in_tlast_i,
    output logic [N_INPUTS-1:0]            in_tready_o,
    output logic                           out_tvalid_o,
    output logic [DATA_WIDTH-1:0]          out_tdata_o,
    output logic                           out_tlast_o,
    input  logic                           out_tready_i,
    output logic [N_INPUTS-1:0]            grant_o,
    output logic                           busy_o,
    output logic [CNT_WIDTH-1:0]           pkt_cnt_o
);

    localparam int PTR_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [N_INPUTS-1:0]  grant_q, grant_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                 req_found;
    logic [PTR_W-1:0]     win_idx;
    logic [PTR_W:0]       search_sum;
    logic [PTR_W-1:0]     search_idx;
    logic [PTR_W-1:0]     ptr_after;
    logic                 last_xfer;

    // Round-robin search: scan ptr, ptr+1, ... modulo N_INPUTS, first hit wins.
    always_comb begin
        req_found  = 1'b0;
        win_idx    = '0;
        search_sum = '0;
        search_idx = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            search_sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
            if (search_sum >= (PTR_W+1)'(N_INPUTS)) begin
                search_sum = search_sum - (PTR_W+1)'(N_INPUTS);
            end
            search_idx = search_sum[PTR_W-1:0];
            if (!req_found && in_tvalid_i[search_idx]) begin
                req_found = 1'b1;
                win_idx   = search_idx;
            end
        end
    end

    // Pointer moves to the input just after the one that finished.
    always_comb begin
        ptr_after = ptr_q;
        for (int k = 0; k < N_INPUTS; k++) begin
            if (grant_q[k]) begin
                ptr_after = (k == N_INPUTS - 1) ? '0 : PTR_W'(k + 1);
            end
        end
    end

    // Output mux straight from the grant register; an all-zero grant (IDLE)
    // leaves every output at zero.
    always_comb begin
        out_tvalid_o = 1'b0;
        out_tdata_o  = '0;
        out_tlast_o  = 1'b0;
        for (int k = 0; k < N_INPUTS; k++) begin
            if (grant_q[k]) begin
                out_tvalid_o = in_tvalid_i[k];
                out_tdata_o  = in_tdata_i[k*DATA_WIDTH +: DATA_WIDTH];
                out_tlast_o  = in_tlast_i[k];
            end
        end
    end

    // Ready depends only on the registered grant, never on in_tvalid_i.
    assign in_tready_o = grant_q & {N_INPUTS{out_tready_i}};
    assign grant_o     = grant_q;
    assign busy_o      = (state_q == LOCKED);
    assign pkt_cnt_o   = cnt_q;
    assign last_xfer   = out_tvalid_o && out_tready_i && out_tlast_o;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_found) begin
                    state_d = LOCKED;
                    grant_d = {{(N_INPUTS-1){1'b0}}, 1'b1} << win_idx;
                end
            end
            LOCKED: begin
                if (last_xfer) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = ptr_after;
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_axis_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_axis_port_arbiter
//
// Directed bench for axis_port_arbiter (N_INPUTS=5, DATA_WIDTH=40,
// CNT_WIDTH=4). A cycle-by-cycle vector table covers reset, round-robin
// order, wormhole locking and pointer wrap; hand-written sequences cover
// backpressure with a mid-packet valid drop, counter wrap and reset
// mid-packet. Inputs change 1 ns after the rising edge, outputs are sampled
// on the falling edge.
// ----------------------------------------------------------------------------
module tb_axis_port_arbiter;

    localparam int N  = 5;
    localparam int DW = 40;
    localparam int CW = 4;
    localparam int NV = 24;

    logic            clk;
    logic            rst;
    logic [N-1:0]    in_tvalid;
    logic [N*DW-1:0] in_tdata;
    logic [N-1:0]    in_tlast;
    logic [N-1:0]    in_tready;
    logic            out_tvalid;
    logic [DW-1:0]   out_tdata;
    logic            out_tlast;
    logic            out_tready;
    logic [N-1:0]    grant;
    logic            busy;
    logic [CW-1:0]   pkt_cnt;

    int checks = 0;
    int errors = 0;

    axis_port_arbiter #(
        .N_INPUTS  (N),
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_tvalid_i (in_tvalid),
        .in_tdata_i  (in_tdata),
        .in_tlast_i  (in_tlast),
        .in_tready_o (in_tready),
        .out_tvalid_o(out_tvalid),
        .out_tdata_o (out_tdata),
        .out_tlast_o (out_tlast),
        .out_tready_i(out_tready),
        .grant_o     (grant),
        .busy_o      (busy),
        .pkt_cnt_o   (pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic [N-1:0] tv;
        logic [N-1:0] tl;
        logic         otr;
        logic [N-1:0] eg;
        logic         eov;
        logic         eol;
        logic         ebusy;
        logic [CW-1:0] ecnt;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t v(input logic r, input logic [N-1:0] tv,
                               input logic [N-1:0] tl, input logic otr,
                               input logic [N-1:0] eg, input logic eov,
                               input logic eol, input logic ebusy,
                               input int ecnt);
        vec_t x;
        x.rst   = r;
        x.tv    = tv;
        x.tl    = tl;
        x.otr   = otr;
        x.eg    = eg;
        x.eov   = eov;
        x.eol   = eol;
        x.ebusy = ebusy;
        x.ecnt  = CW'(ecnt);
        return x;
    endfunction

    // Payload pattern used by the table: input k in vector i carries {k, i}.
    function automatic logic [DW-1:0] exp_data(input logic [N-1:0] g, input int i);
        logic [DW-1:0] d;
        d = '0;
        for (int k = 0; k < N; k++) begin
            if (g[k]) d = {8'(k), 32'(i)};
        end
        return d;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int b;
    logic sv;
    logic xfer;
    logic done;

    initial begin
        // Table: inputs held for one cycle, expected outputs during that cycle.
        // reset with everything valid
        vecs[0]  = v(1, 5'h1F, 5'h1F, 1, 5'h00, 0, 0, 0, 0);
        // round robin with single-beat packets: 0,1,2,3,4,0
        vecs[1]  = v(0, 5'h1F, 5'h1F, 1, 5'h00, 0, 0, 0, 0);
        vecs[2]  = v(0, 5'h1F, 5'h1F, 1, 5'h01, 1, 1, 1, 0);
        vecs[3]  = v(0, 5'h1F, 5'h1F, 1, 5'h00, 0, 0, 0, 1);
        vecs[4]  = v(0, 5'h1F, 5'h1F, 1, 5'h02, 1, 1, 1, 1);
        vecs[5]  = v(0, 5'h1F, 5'h1F, 1, 5'h00, 0, 0, 0, 2);
        vecs[6]  = v(0, 5'h1F, 5'h1F, 1, 5'h04, 1, 1, 1, 2);
        vecs[7]  = v(0, 5'h1F, 5'h1F, 1, 5'h00, 0, 0, 0, 3);
        vecs[8]  = v(0, 5'h1F, 5'h1F, 1, 5'h08, 1, 1, 1, 3);
        vecs[9]  = v(0, 5'h1F, 5'h1F, 1, 5'h00, 0, 0, 0, 4);
        vecs[10] = v(0, 5'h1F, 5'h1F, 1, 5'h10, 1, 1, 1, 4);
        vecs[11] = v(0, 5'h1F, 5'h1F, 1, 5'h00, 0, 0, 0, 5);
        vecs[12] = v(0, 5'h1F, 5'h1F, 1, 5'h01, 1, 1, 1, 5);
        // ptr=1: input 2 wins over 0 and 4, 4-beat packet, others ignored
        vecs[13] = v(0, 5'h15, 5'h00, 1, 5'h00, 0, 0, 0, 6);
        vecs[14] = v(0, 5'h15, 5'h00, 1, 5'h04, 1, 0, 1, 6);
        vecs[15] = v(0, 5'h15, 5'h00, 1, 5'h04, 1, 0, 1, 6);
        vecs[16] = v(0, 5'h15, 5'h00, 1, 5'h04, 1, 0, 1, 6);
        vecs[17] = v(0, 5'h15, 5'h04, 1, 5'h04, 1, 1, 1, 6);
        // ptr=3: input 4 beats input 0
        vecs[18] = v(0, 5'h11, 5'h00, 1, 5'h00, 0, 0, 0, 7);
        vecs[19] = v(0, 5'h11, 5'h10, 1, 5'h10, 1, 1, 1, 7);
        // ptr wrapped to 0: input 1 beats input 4
        vecs[20] = v(0, 5'h12, 5'h00, 1, 5'h00, 0, 0, 0, 8);
        vecs[21] = v(0, 5'h12, 5'h02, 1, 5'h02, 1, 1, 1, 8);
        // no requests: stay idle
        vecs[22] = v(0, 5'h00, 5'h00, 1, 5'h00, 0, 0, 0, 9);
        vecs[23] = v(0, 5'h00, 5'h00, 0, 5'h00, 0, 0, 0, 9);

        rst        = 1'b1;
        in_tvalid  = '1;
        in_tlast   = '1;
        in_tdata   = '0;
        out_tready = 1'b1;
        step();

        for (int i = 0; i < NV; i++) begin
            rst        = vecs[i].rst;
            in_tvalid  = vecs[i].tv;
            in_tlast   = vecs[i].tl;
            out_tready = vecs[i].otr;
            for (int k = 0; k < N; k++) in_tdata[k*DW +: DW] = {8'(k), 32'(i)};
            @(negedge clk);
            chk($sformatf("v%0d_grant", i),  64'(grant),      64'(vecs[i].eg));
            chk($sformatf("v%0d_tready", i), 64'(in_tready),  64'(vecs[i].otr ? vecs[i].eg : 5'h00));
            chk($sformatf("v%0d_ovalid", i), 64'(out_tvalid), 64'(vecs[i].eov));
            chk($sformatf("v%0d_olast", i),  64'(out_tlast),  64'(vecs[i].eol));
            chk($sformatf("v%0d_odata", i),  64'(out_tdata),  64'(exp_data(vecs[i].eg, i)));
            chk($sformatf("v%0d_busy", i),   64'(busy),       64'(vecs[i].ebusy));
            chk($sformatf("v%0d_cnt", i),    64'(pkt_cnt),    64'(vecs[i].ecnt));
            step();
        end

        // Backpressure: ptr=2, inputs 3 and 0 request, input 3 wins.
        // out_tready alternates 1,0,...; input 3 drops valid in cycles 3 and 4.
        in_tvalid  = 5'b01001;
        in_tlast   = 5'b00000;
        out_tready = 1'b1;
        in_tdata   = '0;
        in_tdata[0*DW +: DW] = {8'h00, 32'hDEAD};
        in_tdata[3*DW +: DW] = {8'h03, 32'd0};
        @(negedge clk);
        chk("bp_idle_grant", 64'(grant), 64'h00);
        step();

        b    = 0;
        done = 1'b0;
        for (int c = 0; c < 16 && !done; c++) begin
            out_tready = (c % 2 == 0);
            sv         = !(c == 3 || c == 4);
            in_tvalid  = {1'b0, sv, 2'b00, 1'b1};
            in_tlast   = {1'b0, (b == 3), 3'b000};
            in_tdata[3*DW +: DW] = {8'h03, 32'(b)};
            @(negedge clk);
            chk($sformatf("bp%0d_grant", c),  64'(grant),      64'h08);
            chk($sformatf("bp%0d_tready", c), 64'(in_tready),  64'(out_tready ? 5'h08 : 5'h00));
            chk($sformatf("bp%0d_ovalid", c), 64'(out_tvalid), 64'(sv));
            xfer = sv && out_tready;
            if (xfer) begin
                chk($sformatf("bp%0d_data", c), 64'(out_tdata), 64'({8'h03, 32'(b)}));
                chk($sformatf("bp%0d_last", c), 64'(out_tlast), 64'(b == 3));
            end
            step();
            if (xfer) begin
                b++;
                if (b == 4) done = 1'b1;
            end
        end
        if (!done) begin
            errors++;
            $display("FAIL bp_complete actual=%0d beats expected=4", b);
        end

        // Input 0 single-beat packets until the 4-bit counter wraps.
        in_tvalid = 5'b00001;
        in_tlast  = 5'b00001;
        out_tready = 1'b1;
        in_tdata[0*DW +: DW] = {8'h00, 32'h55};
        @(negedge clk);
        chk("post_bp_grant", 64'(grant), 64'h00);
        chk("post_bp_busy",  64'(busy),  64'h0);
        chk("post_bp_cnt",   64'(pkt_cnt), 64'd10);
        for (int p = 0; p < 6; p++) begin
            step();
            @(negedge clk);
            chk($sformatf("wrap%0d_grant", p), 64'(grant),     64'h01);
            chk($sformatf("wrap%0d_odata", p), 64'(out_tdata), 64'({8'h00, 32'h55}));
            step();
            @(negedge clk);
            chk($sformatf("wrap%0d_cnt", p),   64'(pkt_cnt),   64'((11 + p) % 16));
            chk($sformatf("wrap%0d_idle", p),  64'(grant),     64'h00);
        end

        // Reset during beat 2 of a 4-beat packet from input 2 (ptr=1).
        in_tvalid = 5'b00100;
        in_tlast  = 5'b00000;
        in_tdata[2*DW +: DW] = {8'h02, 32'h77};
        step();
        @(negedge clk);
        chk("rstmid_beat1_grant", 64'(grant),      64'h04);
        chk("rstmid_beat1_valid", 64'(out_tvalid), 64'h1);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_beat2_grant", 64'(grant), 64'h04);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_grant",  64'(grant),      64'h00);
        chk("rstmid_tready", 64'(in_tready),  64'h00);
        chk("rstmid_busy",   64'(busy),       64'h0);
        chk("rstmid_ovalid", 64'(out_tvalid), 64'h0);
        chk("rstmid_odata",  64'(out_tdata),  64'h0);
        chk("rstmid_cnt",    64'(pkt_cnt),    64'h0);
        step();
        @(negedge clk);
        chk("rstmid_regrant", 64'(grant), 64'h04);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_port_arbiter.md
# axis_port_arbiter

Wormhole output-port arbiter for one output direction (HOME/NORTH/EAST/SOUTH/WEST) of the XY mesh router. It shares a single AXI-Stream output link among the router's input ports that have routed a packet to this direction. A packet stays locked to its input until its TLAST beat is accepted. Grants are round-robin, and a wrapping packet counter is exported for the PMU. Five instances, one per output direction, sit between route computation and the output links of each router.

## Interface
Parameters:
- N_INPUTS, 5, number of requesting input ports (index 0 = HOME, 1 = NORTH, 2 = EAST, 3 = SOUTH, 4 = WEST)
- DATA_WIDTH, 40, flit payload width
- CNT_WIDTH, 16, width of the packet counter

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset; synchronous, active-high
- in_tvalid_i  in  N_INPUTS  per-input request; bit k high means input k holds a flit routed to this output
- in_tdata_i  in  N_INPUTS*DATA_WIDTH  flit payloads; input k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- in_tlast_i  in  N_INPUTS  per-input end-of-packet flag
- in_tready_o  out  N_INPUTS  per-input ready; at most one bit high at any time
- out_tvalid_o  out  1  output link valid
- out_tdata_o  out  DATA_WIDTH  output link payload
- out_tlast_o  out  1  output link end-of-packet flag
- out_tready_i  in  1  output link ready
- grant_o  out  N_INPUTS  one-hot owner of the link; all zero when idle
- busy_o  out  1  high while a packet is locked
- pkt_cnt_o  out  CNT_WIDTH  count of completed packets; wraps to 0

## Operation
- State machine with two states, IDLE and LOCKED. The state, grant register, round-robin pointer ptr (clog2(N_INPUTS) bits) and pkt_cnt are registered.
- IDLE:
  - out_tvalid_o = 0, in_tready_o = 0, grant_o = 0, busy_o = 0.
  - If any in_tvalid_i bit is high, select the first requester searching ptr, ptr+1, … modulo N_INPUTS.
  - Next cycle: grant_o is one-hot on the winner and state becomes LOCKED.
  - If no bit is high, stay in IDLE.
- LOCKED, with g = granted index:
  - out_tvalid_o = in_tvalid_i[g], out_tdata_o = slice g of in_tdata_i, out_tlast_o = in_tlast_i[g].
  - in_tready_o[g] = out_tready_i; all other in_tready_o bits = 0.
  - This path is combinational, with no buffering.
- End of packet: a beat transfers when out_tvalid_o && out_tready_i. A transfer with out_tlast_o = 1 causes, on the next edge:
  - state → IDLE, grant cleared;
  - ptr ← (g+1) mod N_INPUTS (with N_INPUTS=5, 4 wraps to 0);
  - pkt_cnt ← pkt_cnt+1, wrapping modulo 2^CNT_WIDTH.
- Boundary behaviour:
  - Input g deasserting valid mid-packet stalls the link. The lock is held indefinitely and no other input is served.
  - Requests from other inputs while LOCKED are ignored and do not move ptr.
  - A single-beat packet (TLAST on its first beat) locks for exactly that beat.
  - Reset mid-packet drops the lock. The upstream is responsible for discarding its partial packet.
- out_tdata_o / out_tlast_o are don't-care while out_tvalid_o = 0; implemented as zero in IDLE.

## Timing
- Reset, effective on the first edge with rst_i = 1: state IDLE, ptr 0, grant_o 0, busy_o 0, pkt_cnt_o 0. Therefore out_tvalid_o = 0, out_tdata_o = 0, out_tlast_o = 0, in_tready_o = 0.
- Arbitration latency:
  - A request seen in IDLE at edge t is granted from cycle t+1.
  - The first beat can transfer in cycle t+1.
- Packet turnaround:
  - The last-beat transfer at edge t returns to IDLE in cycle t+1.
  - The next grant is visible in cycle t+2, so there is one idle bubble between packets.
- Throughput within a packet: one beat per cycle while in_tvalid_i[g] and out_tready_i are both high.
- No combinational path from in_tvalid_i to in_tready_o. in_tready_o depends only on grant_o and out_tready_i.

## Test plan
- Reset/idle: assert rst_i for 2 cycles with all inputs valid → all outputs 0, pkt_cnt_o = 0. Release reset → grant_o = 5'b00001 one cycle later.
- Round-robin fairness: all 5 inputs continuously send 1-beat packets, out_tready_i = 1 → grant order 0,1,2,3,4,0; pkt_cnt_o = 6 after 6 packets. Each packet takes 2 cycles.
- Wormhole lock: input 2 sends a 4-beat packet and input 4 requests from cycle 1 → input 2's 4 beats are contiguous on the output, then input 4 is granted. ptr after input 2's packet = 3.
- Backpressure/stall: out_tready_i toggles 1,0,1,0 and input 3 drops valid for 2 cycles mid-packet → no beat is lost or duplicated, in_tready_o[3] tracks out_tready_i, the grant is held.
- Pointer wrap: only input 4 requests → after its packet ptr = 0. Next, inputs 1 and 4 request together → input 1 is granted.
- Reset mid-packet and counter wrap: with CNT_WIDTH = 4, complete 16 packets → pkt_cnt_o = 0. Pulse rst_i during beat 2 of a 4-beat packet → next cycle IDLE, grant_o = 0, in_tready_o = 0.
